// File: rtl/program_loader.sv
// Program loader: takes a framed byte stream (sync, count, hi/lo data pairs,
// XOR checksum) and writes 16-bit words into instruction memory from address
// 0 upward. The CPU is held in reset until a frame passes its checksum.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [7:0]  i_Byte,
  input  logic        i_ByteValid,
  output logic        o_ByteReady,
  output logic        o_WE,
  output logic [7:0]  o_WAddr,
  output logic [15:0] o_WData,
  output logic        o_CPU_RSTn,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error,
  output logic [1:0]  o_ErrCode
);

  typedef enum logic [2:0] {
    StIdle, StCount, StHi, StLo, StWrite, StCheck, StDone, StErr
  } state_e;

  localparam logic [1:0]  ErrNone     = 2'b00;
  localparam logic [1:0]  ErrChecksum = 2'b01;
  localparam logic [1:0]  ErrTimeout  = 2'b10;
  localparam logic [31:0] TimeoutLast = TIMEOUT - 1;

  state_e      state_q;
  logic [8:0]  word_cnt_q;
  logic [7:0]  csum_q;
  logic [31:0] to_cnt_q;

  logic accept;
  logic waiting;
  logic timeout_hit;

  // Ready is a pure state decode; the loader only stalls the source while writing.
  assign o_ByteReady = (state_q != StWrite);
  assign accept      = i_ByteValid && o_ByteReady;

  // States where a missing byte counts towards the inter-byte timeout.
  assign waiting = (state_q == StCount) || (state_q == StHi) ||
                   (state_q == StLo)    || (state_q == StCheck);
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TimeoutLast);

  // Frame FSM with registered outputs, word counter, checksum and timeout counter.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      csum_q     <= '0;
      to_cnt_q   <= '0;
      o_WE       <= 1'b0;
      o_WAddr    <= '0;
      o_WData    <= '0;
      o_CPU_RSTn <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_Error    <= 1'b0;
      o_ErrCode  <= ErrNone;
    end else begin
      o_WE <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          // Non-sync bytes are consumed and dropped.
          if (accept && (i_Byte == SYNC_BYTE)) begin
            state_q    <= StCount;
            o_CPU_RSTn <= 1'b0;
            o_Done     <= 1'b0;
            o_Error    <= 1'b0;
            o_ErrCode  <= ErrNone;
            csum_q     <= '0;
            o_WAddr    <= '0;
            to_cnt_q   <= '0;
            o_Busy     <= 1'b1;
          end
        end
        StCount: begin
          if (accept) begin
            // A count of zero means a full 256-word image.
            word_cnt_q <= (i_Byte == 8'd0) ? 9'd256 : {1'b0, i_Byte};
            to_cnt_q   <= '0;
            state_q    <= StHi;
          end
        end
        StHi: begin
          if (accept) begin
            o_WData[15:8] <= i_Byte;
            csum_q        <= csum_q ^ i_Byte;
            to_cnt_q      <= '0;
            state_q       <= StLo;
          end
        end
        StLo: begin
          if (accept) begin
            o_WData[7:0] <= i_Byte;
            csum_q       <= csum_q ^ i_Byte;
            to_cnt_q     <= '0;
            o_WE         <= 1'b1;
            state_q      <= StWrite;
          end
        end
        StWrite: begin
          o_WAddr    <= o_WAddr + 8'd1;
          word_cnt_q <= word_cnt_q - 9'd1;
          state_q    <= (word_cnt_q == 9'd1) ? StCheck : StHi;
        end
        StCheck: begin
          if (accept) begin
            to_cnt_q <= '0;
            o_Busy   <= 1'b0;
            if (i_Byte == csum_q) begin
              state_q    <= StDone;
              o_Done     <= 1'b1;
              o_CPU_RSTn <= 1'b1;
            end else begin
              state_q   <= StErr;
              o_Error   <= 1'b1;
              o_ErrCode <= ErrChecksum;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Inter-byte timeout; overrides the case above only on idle cycles.
      if (waiting && !accept && (TIMEOUT != 0)) begin
        if (timeout_hit) begin
          state_q   <= StErr;
          o_Busy    <= 1'b0;
          o_Error   <= 1'b1;
          o_ErrCode <= ErrTimeout;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives frames byte by byte and compares captured
// memory writes and final status against a frame-level reference model.
module tb_program_loader;

  localparam logic [7:0] Sync = 8'hA5;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic [7:0]  i_Byte;
  logic        i_ByteValid;
  logic        o_ByteReady;
  logic        o_WE;
  logic [7:0]  o_WAddr;
  logic [15:0] o_WData;
  logic        o_CPU_RSTn;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Error;
  logic [1:0]  o_ErrCode;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] got[$];       // captured writes {addr, data}
  logic [15:0] tx_words[$];  // words of the frame under test

  program_loader #(.SYNC_BYTE(Sync), .TIMEOUT(8)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_Byte(i_Byte), .i_ByteValid(i_ByteValid),
    .o_ByteReady(o_ByteReady), .o_WE(o_WE), .o_WAddr(o_WAddr), .o_WData(o_WData),
    .o_CPU_RSTn(o_CPU_RSTn), .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error),
    .o_ErrCode(o_ErrCode)
  );

  always #5 i_CLK = ~i_CLK;

  // Capture every write pulse; the loader must not offer ready while writing.
  always @(negedge i_CLK) begin
    if (!i_RST && o_WE) begin
      got.push_back({o_WAddr, o_WData});
      n_cmp++;
      if (o_ByteReady !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_in_write: got %b want 0 (addr %h)", o_ByteReady, o_WAddr);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int guard = 0;
    @(negedge i_CLK);
    i_Byte = b;
    i_ByteValid = 1'b1;
    while (!o_ByteReady && guard < 10) begin
      @(negedge i_CLK);
      guard++;
    end
    if (guard >= 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_stall: ready stuck low, byte %h", b);
    end
    @(posedge i_CLK);
    #1 i_ByteValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) idle($urandom_range(0, max_gap));
  endtask

  // Sends tx_words as one frame and checks writes and status against the model:
  // word k lands at address k mod 256, success iff checksum equals XOR of data.
  task automatic run_frame(input bit force_cs, input logic [7:0] forced, input int max_gap,
                           input string name);
    int n = tx_words.size();
    logic [7:0] x = 8'h00;
    logic [7:0] cs;
    logic [7:0] n8;
    bit ok;
    foreach (tx_words[k]) x = x ^ tx_words[k][15:8] ^ tx_words[k][7:0];
    cs = force_cs ? forced : x;
    ok = (cs == x);
    n8 = n[7:0];
    got.delete();
    send(Sync);
    gap(max_gap);
    send(n8);
    foreach (tx_words[k]) begin
      gap(max_gap);
      send(tx_words[k][15:8]);
      gap(max_gap);
      send(tx_words[k][7:0]);
    end
    gap(max_gap);
    send(cs);
    n_cmp++;
    if (got.size() != n) begin
      n_bad++;
      $display("FAIL %s_wcount: got %0d want %0d", name, got.size(), n);
    end
    for (int k = 0; k < n && k < got.size(); k++) begin
      logic [7:0] a;
      a = k[7:0];
      n_cmp++;
      if (got[k] !== {a, tx_words[k]}) begin
        n_bad++;
        $display("FAIL %s_write%0d: got %h want %h", name, k, got[k], {a, tx_words[k]});
      end
    end
    n_cmp++;
    if ({o_Done, o_Error, o_ErrCode, o_CPU_RSTn, o_Busy, o_WE} !==
        {ok, !ok, ok ? 2'b00 : 2'b01, ok, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_status: got done=%b err=%b code=%b rstn=%b busy=%b we=%b want ok=%b",
               name, o_Done, o_Error, o_ErrCode, o_CPU_RSTn, o_Busy, o_WE, ok);
    end
    n_cmp++;
    if (o_WAddr !== n8) begin
      n_bad++;
      $display("FAIL %s_waddr: got %h want %h", name, o_WAddr, n8);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_cmp++;
    if ({o_WE, o_WAddr, o_WData, o_CPU_RSTn, o_Busy, o_Done, o_Error, o_ErrCode, o_ByteReady}
        !== {1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      n_bad++;
      $display("FAIL %s: got we=%b a=%h d=%h rstn=%b busy=%b done=%b err=%b code=%b rdy=%b",
               name, o_WE, o_WAddr, o_WData, o_CPU_RSTn, o_Busy, o_Done, o_Error,
               o_ErrCode, o_ByteReady);
    end
  endtask

  task automatic test_reset();
    i_RST = 1'b1;
    i_Byte = 8'h00;
    i_ByteValid = 1'b0;
    #12;
    check_reset_vals("reset_values");
    @(negedge i_CLK);
    i_RST = 1'b0;
  endtask

  task automatic test_basic();
    tx_words = '{16'h1234, 16'hABCD};
    run_frame(1'b0, 8'h00, 0, "basic");
    n_cmp++;
    if (o_ErrCode !== 2'b00 || o_Done !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_done: got done=%b code=%b want 1/00", o_Done, o_ErrCode);
    end
  endtask

  task automatic test_bad_checksum();
    tx_words = '{16'h00FF};
    run_frame(1'b1, 8'h00, 0, "badcs");
  endtask

  task automatic test_timeout();
    got.delete();
    send(Sync);
    send(8'h01);
    send(8'h12);
    idle(7);
    n_cmp++;
    if (o_Busy !== 1'b1 || o_Error !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: got busy=%b err=%b want 1/0", o_Busy, o_Error);
    end
    idle(1);
    n_cmp++;
    if ({o_Busy, o_Error, o_ErrCode, o_CPU_RSTn, o_Done} !== {1'b0, 1'b1, 2'b10, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_status: got busy=%b err=%b code=%b rstn=%b done=%b want 0/1/10/0/0",
               o_Busy, o_Error, o_ErrCode, o_CPU_RSTn, o_Done);
    end
    n_cmp++;
    if (got.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_nowrite: got %0d writes want 0", got.size());
    end
  endtask

  task automatic test_full_image();
    tx_words.delete();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = k[7:0];
      tx_words.push_back({b, ~b});
    end
    run_frame(1'b0, 8'h00, 0, "n256");
  endtask

  task automatic test_garbage_reload();
    got.delete();
    send(8'h3C);
    send(8'h77);
    n_cmp++;
    if ({o_Busy, o_Done, o_Error} !== 3'b000 || got.size() != 0) begin
      n_bad++;
      $display("FAIL garbage_ignored: got busy=%b done=%b err=%b writes=%0d want 0/0/0/0",
               o_Busy, o_Done, o_Error, got.size());
    end
    test_basic();
    send(Sync);
    n_cmp++;
    if ({o_CPU_RSTn, o_Done, o_Busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL reload_holds_cpu: got rstn=%b done=%b busy=%b want 0/0/1",
               o_CPU_RSTn, o_Done, o_Busy);
    end
    send(8'h01);
    send(8'h55);
    send(8'hAA);
    send(8'hFF);
    n_cmp++;
    if ({o_Done, o_CPU_RSTn} !== 2'b11) begin
      n_bad++;
      $display("FAIL reload_done: got done=%b rstn=%b want 1/1", o_Done, o_CPU_RSTn);
    end
  endtask

  task automatic test_reset_mid_frame();
    got.delete();
    send(Sync);
    send(8'h01);
    send(8'h12);
    @(negedge i_CLK);
    #2 i_RST = 1'b1;
    #1 check_reset_vals("midreset_async");
    @(negedge i_CLK);
    i_RST = 1'b0;
    send(8'h34);
    idle(3);
    n_cmp++;
    if (got.size() != 0 || o_Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_nowrite: got writes=%0d busy=%b want 0/0", got.size(), o_Busy);
    end
    tx_words = '{16'hCAFE, 16'hA5A5, 16'h0001};
    run_frame(1'b0, 8'h00, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 8);
      bit force_cs = $urandom_range(0, 1) == 1;
      logic [7:0] forced = 8'($urandom);
      tx_words.delete();
      for (int k = 0; k < n; k++) tx_words.push_back(16'($urandom));
      if (r == 0) tx_words[0] = {Sync, Sync};  // sync value inside data
      run_frame(force_cs, forced, 3, "random");
    end
  endtask

  initial begin
    test_reset();
    test_garbage_reload();
    test_basic();
    test_bad_checksum();
    test_timeout();
    test_full_image();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic test_back_to_back();
    tx_words = '{16'h0102};
    run_frame(1'b0, 8'h00, 0, "b2b_a");
    tx_words = '{16'h0304, 16'h0506};
    run_frame(1'b1, 8'h11, 0, "b2b_b");
    tx_words = '{16'hFFFF};
    run_frame(1'b0, 8'h00, 0, "b2b_c");
  endtask

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream and writes 16-bit instruction words into instruction memory from address 0 upward.
- Holds the CPU core in reset while a load is in progress and releases it after a frame passes its checksum.
- Sits between a byte source (UART receiver or debug port) and the instruction memory write port; the core's PC reads that same memory.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- i_CLK  in  1  system clock; all state changes on the rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_Byte  in  8  incoming stream byte.
- i_ByteValid  in  1  i_Byte holds a valid byte.
- o_ByteReady  out  1  loader can accept a byte; a transfer happens on a rising edge where valid and ready are both 1.
- o_WE  out  1  instruction memory write enable, one-cycle pulse per word.
- o_WAddr  out  8  write address.
- o_WData  out  16  write data; high byte first on the wire.
- o_CPU_RSTn  out  1  CPU reset, active low; 0 holds the core in reset.
- o_Busy  out  1  a frame is in progress.
- o_Done  out  1  last frame loaded successfully.
- o_Error  out  1  last frame failed.
- o_ErrCode  out  2  failure cause: 01 checksum, 10 timeout, 00 none.

Behaviour:
- Frame format: SYNC_BYTE, then count N (N=0 means 256 words), then 2N data bytes (hi, lo per word), then a checksum byte equal to the XOR of all 2N data bytes.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR.
- Reset values: state IDLE; o_WE=0, o_WAddr=0, o_WData=0, o_CPU_RSTn=0, o_Busy=0, o_Done=0, o_Error=0, o_ErrCode=00; internal word counter (9 bits), checksum and timeout counter all cleared.
- o_ByteReady is decoded from state: 1 in every state except WRITE. It reads 1 while in reset.
- IDLE/DONE/ERR:
  - An accepted byte equal to SYNC_BYTE goes to COUNT. In the same edge: o_CPU_RSTn=0, o_Done=0, o_Error=0, o_ErrCode=00, checksum=0, o_WAddr=0.
  - Any other byte is consumed and ignored.
- COUNT: the accepted byte loads the word counter (0 loads 256), then go to HI.
- HI: the accepted byte is latched into o_WData[15:8] and XORed into the checksum; go to LO.
- LO: the accepted byte is latched into o_WData[7:0] and XORed into the checksum; go to WRITE.
- WRITE (exactly 1 cycle):
  - o_WE=1 with o_WAddr and o_WData stable; no byte is accepted.
  - On exit, o_WAddr increments (8-bit wrap) and the word counter decrements.
  - Go to CHECK if the counter reaches 0, otherwise go to HI.
- CHECK: the accepted byte is compared with the running checksum.
  - Equal: go to DONE; o_Done=1, o_CPU_RSTn=1.
  - Not equal: go to ERR; o_Error=1, o_ErrCode=01; o_CPU_RSTn stays 0.
- o_WE is 0 in every state except WRITE.
- o_Busy=1 in COUNT, HI, LO, WRITE and CHECK.
- Timeout:
  - The counter clears on every accepted byte and on entry to COUNT.
  - It increments each cycle in COUNT/HI/LO/CHECK while no byte is accepted.
  - When it reaches TIMEOUT: go to ERR, o_ErrCode=10, o_CPU_RSTn stays 0.
  - The counter does not run in WRITE. TIMEOUT=0 disables this check.
- Write latency: o_WE rises on the edge after the lo byte is accepted.
- Words already written before an error are not undone. The CPU stays in reset until a later frame succeeds.
- Sync byte inside a frame: treated as ordinary data, with no resync.
- i_RST mid-frame: immediate return to reset values, and any o_WE in progress is dropped.
- A DONE→COUNT transition pulls o_CPU_RSTn low in the same edge, so a reload re-holds the CPU.

Test Plan:
- Basic load: stream A5 02 12 34 AB CD 40, valid every cycle.
  - Required: o_WE pulses with (00,1234) then (01,ABCD).
  - o_ByteReady=0 in each WRITE cycle.
  - o_Done=1, o_CPU_RSTn=1 after the checksum byte; o_ErrCode=00.
- Bad checksum: A5 01 00 FF 00.
  - Required: one write (00,00FF); o_Error=1, o_ErrCode=01, o_CPU_RSTn=0, o_Done=0.
- Timeout with TIMEOUT=8: A5 01 12, then valid held low for 8 cycles.
  - Required: ERR, o_ErrCode=10, o_Busy=0, no o_WE pulse.
- N=0: A5 00, then 512 bytes with word k = {k, ~k}, then checksum 00.
  - Required: 256 writes at addresses 00..FF, o_WAddr wraps to 00, o_Done=1.
- Garbage and reload: 3C 77 in IDLE are ignored (no state change). Then the basic load completes, then A5 starts a new frame.
  - Required: on A5, o_CPU_RSTn drops to 0 and o_Done clears in the same edge.
- Reset mid-frame: assert i_RST between the hi and lo bytes.
  - Required: all outputs go to reset values asynchronously and no write occurs.
  - The next frame loads correctly from address 00.
